boot_sequencer: RTL
===================

Name: boot_sequencer

Overview:
- Sequences the single-cycle core through load → run → halt.
- Accepts instruction words over a valid/ready stream and writes them into the core's instruction memory through its write port (instr_in / instr_wr_addr / instr_wr_en).
- Holds the core in reset while loading, then releases it for a programmed cycle budget.
- Sits between the host/loader interface and the core top level; replaces hand-driven load sequences.

Parameters:
- WIDTH, 32, instruction word width.
- SIZE, 64, instruction memory depth in words.
- LOGSIZE, $clog2(SIZE), derived (localparam).
- CWIDTH, 16, width of the run-cycle budget and counter.

Ports:
- clk  in  1  system clock, all state on posedge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- load_start  in  1  begin a load session; honoured in IDLE and DONE only.
- run_cycles  in  CWIDTH  run budget in cycles, latched on an accepted load_start; 0 = unlimited.
- halt_req  in  1  stop the core while in RUN.
- s_valid  in  1  stream word valid.
- s_ready  out  1  stream ready; 1 only in LOAD.
- s_data  in  WIDTH  instruction word.
- s_last  in  1  marks the final word of the program.
- instr_in  out  WIDTH  memory write data, registered.
- instr_wr_addr  out  LOGSIZE+2  byte address = word index × 4, registered.
- instr_wr_en  out  1  memory write enable, registered.
- core_reset  out  1  active-high reset to the core, registered.
- words_loaded  out  LOGSIZE+1  words accepted in the current or last session.
- cycles_run  out  CWIDTH  core cycles executed in the current or last run.
- state  out  3  IDLE=0, LOAD=1, FLUSH=2, SETTLE=3, RUN=4, DONE=5.
- done  out  1  high in DONE.
- err_overflow  out  1  sticky: SIZE words accepted without s_last; cleared on the next accepted load_start.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE, core_reset=1.
  - instr_in, instr_wr_addr, instr_wr_en = 0.
  - words_loaded, cycles_run, done, err_overflow = 0.
  - s_ready=0 (decoded from state).
- IDLE:
  - core_reset=1.
  - load_start → LOAD: words_loaded←0, err_overflow←0, budget←run_cycles.
- LOAD:
  - s_ready=1.
  - Handshake = s_valid & s_ready, sampled at posedge.
  - On handshake, next edge: instr_in←s_data, instr_wr_addr←words_loaded×4, instr_wr_en←1, words_loaded++.
  - Without a handshake: instr_wr_en←0 (single-cycle write pulses; no duplicate writes).
  - Handshake with s_last → FLUSH.
  - Handshake on word index SIZE-1 without s_last → FLUSH with err_overflow←1; no further words accepted.
  - load_start and halt_req are ignored.
- FLUSH (1 cycle): the last write is presented on the registered outputs. At the exit edge, instr_* ← 0. → SETTLE.
- SETTLE (1 cycle):
  - Write port idle, core_reset still 1.
  - At the exit edge: core_reset←0, cycles_run←0. → RUN.
  - The core's reset falls exactly 2 edges after the last-word handshake edge.
- RUN:
  - cycles_run increments every edge.
  - If budget≠0 and cycles_run+1==budget → at that edge core_reset←1, → DONE. The core executes exactly budget cycles.
  - halt_req=1 → at that edge core_reset←1, → DONE. halt_req together with budget expiry: same outcome, cycles_run = budget.
  - Budget 0: runs until halt_req.
  - cycles_run saturates at all-ones; no wrap.
  - load_start is ignored.
- DONE:
  - core_reset=1, done=1.
  - words_loaded and cycles_run hold their values.
  - load_start → LOAD (reload; memory is overwritten from address 0).
- Async reset at any point, including mid-LOAD or mid-RUN, returns to IDLE with reset values. Instruction memory contents are then undefined/partial and are not cleared by this block.
- s_data/s_last are don't-care when the handshake does not fire.
- Back-to-back valid words are accepted one per cycle with no bubbles.

Test Plan:
- Reset, load_start with run_cycles=9, stream 10 words (0x00000013 + i), s_last on word 9:
  - writes to addresses 0,4,…,36 with matching data, one pulse each;
  - core_reset falls 2 edges after the last handshake;
  - exactly 9 RUN cycles, then DONE, cycles_run=9, words_loaded=10.
- s_valid toggled every other cycle, 4 words:
  - instr_wr_en pulses only on edges following handshakes;
  - addresses 0,4,8,12 contiguous; no duplicates.
- 64 words with no s_last:
  - err_overflow=1, words_loaded=64;
  - s_ready=0 after the 64th word;
  - last write at address 252.
- run_cycles=0, load 1 word (s_last on first), halt_req after 20 RUN cycles:
  - DONE with cycles_run=20;
  - core_reset=1 at the halt edge.
- reset=0 during LOAD after 3 words:
  - immediate IDLE, all outputs at reset values;
  - a new load_start restarts at address 0.
- From DONE, load_start with run_cycles=5:
  - err_overflow and words_loaded cleared;
  - reload from address 0;
  - load_start pulses while in LOAD or RUN have no effect.

Source files
------------

// File: rtl/boot_sequencer.sv
// rtl/boot_sequencer.sv - load/run/halt sequencer for the single-cycle core
//
// Streams a program into the core's instruction memory while holding the
// core in reset, then releases it for a programmed cycle budget.
//
// Ports:
//   clk, reset          system clock; asynchronous active-low reset
//   load_start          start a load session (honoured in IDLE and DONE)
//   run_cycles          run budget latched with load_start, 0 = unlimited
//   halt_req            stop the core while running
//   s_valid/s_ready/s_data/s_last   instruction word stream
//   instr_in/instr_wr_addr/instr_wr_en   registered memory write port
//   core_reset          registered active-high reset to the core
//   words_loaded        words accepted in the current/last session
//   cycles_run          core cycles executed in the current/last run
//   state/done          sequencer state and DONE flag
//   err_overflow        sticky: memory filled without s_last
module boot_sequencer #(
  parameter int WIDTH  = 32,
  parameter int SIZE   = 64,
  parameter int CWIDTH = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           load_start,
  input  logic [CWIDTH-1:0]              run_cycles,
  input  logic                           halt_req,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [WIDTH-1:0]               s_data,
  input  logic                           s_last,
  output logic [WIDTH-1:0]               instr_in,
  output logic [$clog2(SIZE)+1:0]        instr_wr_addr,
  output logic                           instr_wr_en,
  output logic                           core_reset,
  output logic [$clog2(SIZE):0]          words_loaded,
  output logic [CWIDTH-1:0]              cycles_run,
  output logic [2:0]                     state,
  output logic                           done,
  output logic                           err_overflow
);

  localparam int LOGSIZE = $clog2(SIZE);
  localparam logic [LOGSIZE:0] LAST_IDX = (LOGSIZE+1)'(SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_FLUSH  = 3'd2,
    S_SETTLE = 3'd3,
    S_RUN    = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CWIDTH-1:0]  budget_q;
  logic               handshake;
  logic               start_ok;
  logic               overflow_word;
  logic               budget_hit;
  logic               run_exit;
  logic [CWIDTH:0]    cycles_inc;

  assign state   = state_q;
  assign s_ready = (state_q == S_LOAD);
  assign done    = (state_q == S_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    handshake     = 1'b0;
    start_ok      = 1'b0;
    overflow_word = 1'b0;
    budget_hit    = 1'b0;
    run_exit      = 1'b0;
    // Extra carry bit lets the budget compare and saturation avoid wrap.
    cycles_inc    = {1'b0, cycles_run} + (CWIDTH+1)'(1);
    state_d       = state_q;

    handshake     = s_valid && (state_q == S_LOAD);
    start_ok      = load_start && ((state_q == S_IDLE) || (state_q == S_DONE));
    overflow_word = handshake && !s_last && (words_loaded == LAST_IDX);
    budget_hit    = (budget_q != '0) && (cycles_inc == {1'b0, budget_q});
    run_exit      = (state_q == S_RUN) && (halt_req || budget_hit);

    case (state_q)
      S_IDLE:   if (start_ok) state_d = S_LOAD;
      S_LOAD:   if (handshake && (s_last || overflow_word)) state_d = S_FLUSH;
      S_FLUSH:  state_d = S_SETTLE;
      S_SETTLE: state_d = S_RUN;
      S_RUN:    if (run_exit) state_d = S_DONE;
      S_DONE:   if (start_ok) state_d = S_LOAD;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_in      <= '0;
      instr_wr_addr <= '0;
      instr_wr_en   <= 1'b0;
      core_reset    <= 1'b1;
      words_loaded  <= '0;
      cycles_run    <= '0;
      err_overflow  <= 1'b0;
      budget_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          core_reset <= 1'b1;
          if (start_ok) begin
            words_loaded <= '0;
            err_overflow <= 1'b0;
            budget_q     <= run_cycles;
          end
        end
        S_LOAD: begin
          if (handshake) begin
            instr_in      <= s_data;
            instr_wr_addr <= {words_loaded[LOGSIZE-1:0], 2'b00};
            instr_wr_en   <= 1'b1;
            words_loaded  <= words_loaded + (LOGSIZE+1)'(1);
            if (overflow_word) err_overflow <= 1'b1;
          end else begin
            // One pulse per accepted word; data/address simply hold.
            instr_wr_en <= 1'b0;
          end
        end
        S_FLUSH: begin
          instr_in      <= '0;
          instr_wr_addr <= '0;
          instr_wr_en   <= 1'b0;
        end
        S_SETTLE: begin
          core_reset <= 1'b0;
          cycles_run <= '0;
        end
        S_RUN: begin
          if (!cycles_inc[CWIDTH]) cycles_run <= cycles_inc[CWIDTH-1:0];
          if (run_exit) core_reset <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
